sprite_board_mover: RTL and testbench

Multi-sprite board update engine for the Pac-Man tile board. It accepts per-sprite move requests (Pac-Man plus ghosts), arbitrates them round-robin, and checks each destination tile in board RAM for walls, pellets and other sprites. Accepted moves restore the vacated tile and draw the sprite at its new tile. It sits between the sprite behaviour modules and the dual-port board RAM, runs entirely on CLOCK_50, and replaces the single-sprite erase/draw FSM of the top level.

---
 rtl/sprite_board_mover.sv | 197 +++++++++++++++++++
 tb/tb_sprite_board_mover.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_board_mover.sv
// rtl/sprite_board_mover.sv - round-robin multi-sprite move engine for the tile board RAM
module sprite_board_mover #(
  parameter int N_SPR    = 4,
  parameter int COLS     = 32,
  parameter int ROWS     = 24,
  parameter int ADDR_W   = 10,
  parameter int TILE_W   = 4,
  parameter int T_EMPTY  = 0,
  parameter int T_PELLET = 1,
  parameter int T_WALL   = 2
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [N_SPR-1:0]          req,
  input  logic [N_SPR*ADDR_W-1:0]   dst,
  input  logic [N_SPR*ADDR_W-1:0]   init_loc,
  input  logic [N_SPR*TILE_W-1:0]   spr_tile,
  output logic [N_SPR*ADDR_W-1:0]   loc,
  output logic [N_SPR-1:0]          ack,
  output logic                      blocked,
  output logic                      eat,
  output logic                      collide,
  output logic                      busy,
  output logic [ADDR_W-1:0]         ram_rdaddr,
  input  logic [TILE_W-1:0]         ram_q,
  output logic                      ram_wren,
  output logic [ADDR_W-1:0]         ram_wraddr,
  output logic [TILE_W-1:0]         ram_wdata
);

  localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1;
  localparam logic [ADDR_W:0]   C_TILES  = (ADDR_W+1)'(COLS*ROWS);
  localparam logic [TILE_W-1:0] C_EMPTY  = TILE_W'(T_EMPTY);
  localparam logic [TILE_W-1:0] C_PELLET = TILE_W'(T_PELLET);
  localparam logic [TILE_W-1:0] C_WALL   = TILE_W'(T_WALL);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ARB, S_RD_WAIT, S_CHECK, S_RESTORE, S_DRAW, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic [IW-1:0]     r_idx, r_g, r_rr, w_grant;
  logic [ADDR_W-1:0] r_loc [N_SPR];
  logic [TILE_W-1:0] r_under [N_SPR];
  logic [ADDR_W-1:0] w_dst [N_SPR];
  logic [ADDR_W-1:0] w_init [N_SPR];
  logic [TILE_W-1:0] w_tile [N_SPR];
  logic [ADDR_W-1:0] r_d, r_rdaddr;
  logic [TILE_W-1:0] r_t;
  logic              r_blk, r_col;
  logic [N_SPR-1:0]  r_served, w_elig;
  logic              w_found, w_match, w_col, w_reject, w_null;
  int                w_dist, w_best;

  always_comb begin
    for (int i = 0; i < N_SPR; i++) begin
      w_dst[i]  = dst[i*ADDR_W +: ADDR_W];
      w_init[i] = init_loc[i*ADDR_W +: ADDR_W];
      w_tile[i] = spr_tile[i*TILE_W +: TILE_W];
      loc[i*ADDR_W +: ADDR_W] = r_loc[i];
    end
  end

  assign w_elig     = req & ~r_served;
  assign ram_rdaddr = r_rdaddr;
  assign busy       = (r_state != S_IDLE);

  // Grant the eligible sprite nearest to r_rr going upward with wrap.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_best  = N_SPR;
    w_dist  = 0;
    for (int j = 0; j < N_SPR; j++) begin
      w_dist = (j >= int'(r_rr)) ? (j - int'(r_rr)) : (j + N_SPR - int'(r_rr));
      if (w_elig[j] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_grant = IW'(j);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_match = 1'b0;
    w_col   = 1'b0;
    for (int j = 0; j < N_SPR; j++) begin
      if ((IW'(j) != r_g) && (r_loc[j] == r_d)) begin
        w_match = 1'b1;
        if ((r_g == '0) || (j == 0)) w_col = 1'b1;
      end
    end
  end

  assign w_reject = ({1'b0, r_d} >= C_TILES) || (ram_q == C_WALL) || w_match;
  assign w_null   = (r_d == r_loc[r_g]);

  always_comb begin
    w_next     = r_state;
    ram_wren   = 1'b0;
    ram_wraddr = '0;
    ram_wdata  = '0;
    ack        = '0;
    blocked    = 1'b0;
    collide    = 1'b0;
    eat        = 1'b0;
    case (r_state)
      S_INIT: begin
        ram_wren   = 1'b1;
        ram_wraddr = r_loc[r_idx];
        ram_wdata  = w_tile[r_idx];
        if (r_idx == IW'(N_SPR-1)) w_next = S_IDLE;
      end
      S_IDLE:    if (|w_elig) w_next = S_ARB;
      S_ARB:     w_next = w_found ? S_RD_WAIT : S_IDLE;
      S_RD_WAIT: w_next = S_CHECK;
      S_CHECK:   w_next = w_reject ? S_DONE : S_RESTORE;
      S_RESTORE: begin
        ram_wren   = 1'b1;
        ram_wraddr = r_loc[r_g];
        ram_wdata  = r_under[r_g];
        w_next     = S_DRAW;
      end
      S_DRAW: begin
        ram_wren   = 1'b1;
        ram_wraddr = r_d;
        ram_wdata  = w_tile[r_g];
        eat        = (r_g == '0) && (r_t == C_PELLET) && !w_null;
        w_next     = S_DONE;
      end
      S_DONE: begin
        ack[r_g] = 1'b1;
        blocked  = r_blk;
        collide  = r_col;
        w_next   = S_IDLE;
      end
      default: w_next = S_INIT;
    endcase
    // Nothing reaches the RAM or the behaviour modules while reset is held.
    if (reset) begin
      ram_wren   = 1'b0;
      ram_wraddr = '0;
      ram_wdata  = '0;
      ack        = '0;
      blocked    = 1'b0;
      collide    = 1'b0;
      eat        = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state  <= S_INIT;
      r_idx    <= '0;
      r_g      <= '0;
      r_rr     <= '0;
      r_d      <= '0;
      r_rdaddr <= '0;
      r_t      <= '0;
      r_blk    <= 1'b0;
      r_col    <= 1'b0;
      r_served <= '0;
      for (int i = 0; i < N_SPR; i++) begin
        r_loc[i]   <= w_init[i];
        r_under[i] <= C_EMPTY;
      end
    end else begin
      r_state <= w_next;
      if (tick) r_served <= '0;
      case (r_state)
        S_INIT: r_idx <= (r_idx == IW'(N_SPR-1)) ? '0 : r_idx + IW'(1);
        S_ARB: begin
          if (w_found) begin
            r_g      <= w_grant;
            r_d      <= w_dst[w_grant];
            r_rdaddr <= w_dst[w_grant];
            r_rr     <= (w_grant == IW'(N_SPR-1)) ? '0 : w_grant + IW'(1);
          end
        end
        S_CHECK: begin
          r_t   <= ram_q;
          r_blk <= w_reject;
          r_col <= w_col;
        end
        // A null move reads back the sprite's own tile, so under must not change.
        S_DRAW: if (!w_null) r_under[r_g] <= ((r_g == '0) && (r_t == C_PELLET)) ? C_EMPTY : r_t;
        S_DONE: begin
          r_served[r_g] <= 1'b1;
          if (!r_blk) r_loc[r_g] <= r_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_board_mover.sv
// tb/tb_sprite_board_mover.sv - randomized self-checking bench with a board-level move model
module tb_sprite_board_mover;
  localparam int N = 4;
  localparam int AW = 10;
  localparam int TW = 4;
  localparam int NTILES = 32*24;

  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*AW-1:0] dst = '0;
  logic [N*AW-1:0] init_loc = {10'd30, 10'd20, 10'd10, 10'd495};
  logic [N*TW-1:0] spr_tile = {4'd7, 4'd6, 4'd5, 4'd4};
  logic [N*AW-1:0] loc;
  logic [N-1:0] ack;
  logic blocked, eat, collide, busy, ram_wren;
  logic [AW-1:0] ram_rdaddr, ram_wraddr;
  logic [TW-1:0] ram_q, ram_wdata;

  logic [TW-1:0] ram [0:1023];
  logic tb_we = 1'b0;
  logic [AW-1:0] tb_wa = '0;
  logic [TW-1:0] tb_wd = '0;

  int m_loc[N], m_under[N], m_dst[N], m_tile[N], m_init[N];
  int m_board[1024];
  int m_rr;
  int checks = 0;
  int errors = 0;

  sprite_board_mover dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick), .req(req), .dst(dst),
    .init_loc(init_loc), .spr_tile(spr_tile), .loc(loc), .ack(ack),
    .blocked(blocked), .eat(eat), .collide(collide), .busy(busy),
    .ram_rdaddr(ram_rdaddr), .ram_q(ram_q), .ram_wren(ram_wren),
    .ram_wraddr(ram_wraddr), .ram_wdata(ram_wdata)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (tb_we) ram[tb_wa] <= tb_wd;
    else if (ram_wren) ram[ram_wraddr] <= ram_wdata;
    ram_q <= ram[ram_rdaddr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input int v);
    tb_we = 1'b1;
    tb_wa = AW'(a);
    tb_wd = TW'(v);
    m_board[a] = v;
    @(posedge CLOCK_50); #1;
    tb_we = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(posedge CLOCK_50); #1;
    tick = 1'b0;
  endtask

  task automatic set_dst(input int g, input int d);
    m_dst[g] = d;
    dst[g*AW +: AW] = AW'(d);
  endtask

  task automatic release_and_check_init();
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge CLOCK_50);
      chk("init_wren", 32'(ram_wren), 1);
      chk("init_addr", 32'(ram_wraddr), m_init[k]);
      chk("init_data", 32'(ram_wdata), m_tile[k]);
      m_board[m_init[k]] = m_tile[k];
    end
    @(negedge CLOCK_50);
    chk("init_busy", 32'(busy), 0);
    @(posedge CLOCK_50); #1;
    for (int k = 0; k < N; k++) begin
      m_loc[k] = m_init[k];
      m_under[k] = 0;
      chk("init_loc", 32'(loc[k*AW +: AW]), m_loc[k]);
    end
    m_rr = 0;
  endtask

  // Request for g is already visible; the next falling edge is the IDLE cycle.
  task automatic expect_move(input int g);
    int d, t, lat, nw, neat;
    bit match, col, rej, null_mv, exp_eat;
    logic [N-1:0] ackv;
    logic blk, col_o;
    logic [AW-1:0] wa[2];
    logic [TW-1:0] wd[2];
    d = m_dst[g];
    t = m_board[d];
    match = 0; col = 0;
    for (int j = 0; j < N; j++)
      if (j != g && m_loc[j] == d) begin
        match = 1;
        if (g == 0 || j == 0) col = 1;
      end
    rej = (d >= NTILES) || (t == 2) || match;
    null_mv = (d == m_loc[g]);
    exp_eat = !rej && g == 0 && t == 1 && !null_mv;
    lat = -1; nw = 0; neat = 0; ackv = '0; blk = 1'b0; col_o = 1'b0;
    wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
    for (int c = 0; c < 12 && lat < 0; c++) begin
      @(negedge CLOCK_50);
      if (ram_wren) begin
        if (nw < 2) begin wa[nw] = ram_wraddr; wd[nw] = ram_wdata; end
        nw++;
      end
      if (eat) neat++;
      if (ack != '0) begin lat = c; ackv = ack; blk = blocked; col_o = collide; end
    end
    chk("latency", lat, rej ? 4 : 6);
    chk("ack_vec", 32'(ackv), 1 << g);
    chk("blocked", 32'(blk), 32'(rej));
    chk("collide", 32'(col_o), 32'(col));
    chk("eat_count", neat, 32'(exp_eat));
    chk("write_count", nw, rej ? 0 : 2);
    if (!rej) begin
      chk("restore_addr", 32'(wa[0]), m_loc[g]);
      chk("restore_data", 32'(wd[0]), m_under[g]);
      chk("draw_addr", 32'(wa[1]), d);
      chk("draw_data", 32'(wd[1]), m_tile[g]);
      m_board[m_loc[g]] = m_under[g];
      m_board[d] = m_tile[g];
      if (!null_mv) m_under[g] = (g == 0 && t == 1) ? 0 : t;
      m_loc[g] = d;
    end
    m_rr = (g + 1) % N;
  endtask

  task automatic move(input int g, input int d);
    set_dst(g, d);
    req[g] = 1'b1;
    expect_move(g);
    @(posedge CLOCK_50); #1;
    req[g] = 1'b0;
    chk("loc", 32'(loc[g*AW +: AW]), m_loc[g]);
  endtask

  function automatic int rnd_dst(input int g);
    int r, nd;
    r = $urandom_range(0, 9);
    if (r == 0) return NTILES + $urandom_range(0, 255);
    if (r == 1) return m_loc[$urandom_range(0, N-1)];
    case ($urandom_range(0, 3))
      0: nd = m_loc[g] + 1;
      1: nd = m_loc[g] - 1;
      2: nd = m_loc[g] + 32;
      default: nd = m_loc[g] - 32;
    endcase
    if (nd < 0) nd = 0;
    if (nd > 1023) nd = 1023;
    return nd;
  endfunction

  // All sprites request after one tick; grants follow round-robin from m_rr.
  task automatic multi_round();
    bit [N-1:0] pend;
    int g, extra;
    for (int i = 0; i < N; i++) set_dst(i, rnd_dst(i));
    do_tick();
    req = '1;
    pend = '1;
    for (int k = 0; k < N; k++) begin
      g = -1;
      for (int o = 0; o < N; o++)
        if (g < 0 && pend[(m_rr + o) % N]) g = (m_rr + o) % N;
      pend[g] = 1'b0;
      expect_move(g);
    end
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLOCK_50);
      if (ack != '0) extra++;
    end
    chk("no_extra_ack", extra, 0);
    chk("idle_after_round", 32'(busy), 0);
    @(posedge CLOCK_50); #1;
    for (int i = 0; i < N; i++) chk("round_loc", 32'(loc[i*AW +: AW]), m_loc[i]);
  endtask

  initial begin
    int nw, d, v;
    for (int k = 0; k < N; k++) begin
      m_init[k] = int'(init_loc[k*AW +: AW]);
      m_tile[k] = int'(spr_tile[k*TW +: TW]);
    end
    @(posedge CLOCK_50); #1;
    for (int a = 0; a < 1024; a++) begin
      v = $urandom_range(0, 9);
      poke(a, (v < 6) ? 0 : (v < 8) ? 1 : 2);
    end
    poke(496, 1);
    poke(11, 1);
    poke(12, 0);
    poke(497, 2);

    @(negedge CLOCK_50);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_wren", 32'(ram_wren), 0);
    chk("rst_rdaddr", 32'(ram_rdaddr), 0);
    chk("rst_pulses", {29'd0, blocked, eat, collide}, 0);
    chk("rst_busy", 32'(busy), 1);
    @(posedge CLOCK_50); #1;
    release_and_check_init();

    do_tick(); move(0, 496);
    do_tick(); move(1, 11);
    do_tick(); move(1, 12);
    do_tick(); move(0, 497);
    do_tick(); move(2, m_loc[0]);
    do_tick(); move(1, m_loc[3]);
    do_tick(); move(3, 800);
    do_tick(); move(3, m_loc[3]);

    multi_round();
    multi_round();
    req = '0;

    // Reset while the CHECK cycle of an acceptable move is in progress.
    d = m_loc[2] + 1;
    for (int j = 0; j < N; j++) if (m_loc[j] == d) d = d + 1;
    poke(d, 0);
    do_tick();
    set_dst(2, d);
    req[2] = 1'b1;
    nw = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLOCK_50);
      if (ram_wren) nw++;
      @(posedge CLOCK_50); #1;
    end
    reset = 1'b1;
    req = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLOCK_50);
      if (ram_wren) nw++;
      chk("reset_ack", 32'(ack), 0);
      @(posedge CLOCK_50); #1;
    end
    chk("reset_no_write", nw, 0);
    release_and_check_init();

    for (int n = 0; n < 40; n++) begin
      int g;
      g = $urandom_range(0, N-1);
      do_tick();
      move(g, rnd_dst(g));
    end
    multi_round();
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
